// File: rtl/pc_source_sel.sv
// ---------------------------------------------------------------------------
// pc_source_sel
//
// Registered next-PC selector for the multicycle datapath. On each load
// strobe it loads data_out with either one of NUM_SRC datapath sources or,
// when an unmasked exception is pending, the vector VEC_BASE + cause index.
// Exception requests are latched in a pending register until serviced.
//
// Strobe semantics: there is no valid/ready handshake. The control FSM
// raises load for one cycle per update. The registered state is read on
// that edge, and data_out/cause/exc_taken show the result from the next
// cycle onward. load may stay high every cycle, which gives back-to-back
// updates.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-low reset
//   sel        in   datapath source select (sampled only when load=1)
//   data_in    in   flattened sources, source k at [k*WIDTH +: WIDTH]
//   exc_req    in   per-cause exception request; each high cycle sets pending
//   exc_mask   in   per-cause mask; 1 = cause may not be taken
//   load       in   update data_out on this edge
//   data_out   out  registered next-PC value
//   cause      out  index of the last exception taken
//   exc_taken  out  one-cycle pulse after an exception vector is loaded
//   pending    out  current pending register
// ---------------------------------------------------------------------------
module pc_source_sel #(
    parameter int WIDTH    = 32,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 2,
    parameter int NUM_EXC  = 3,
    parameter int CAUSE_W  = 2,
    parameter int VEC_BASE = 253
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_SRC*WIDTH-1:0] data_in,
    input  logic [NUM_EXC-1:0]       exc_req,
    input  logic [NUM_EXC-1:0]       exc_mask,
    input  logic                     load,
    output logic [WIDTH-1:0]         data_out,
    output logic [CAUSE_W-1:0]       cause,
    output logic                     exc_taken,
    output logic [NUM_EXC-1:0]       pending
);

    logic [WIDTH-1:0]   data_q,    data_d;
    logic [CAUSE_W-1:0] cause_q,   cause_d;
    logic               taken_q,   taken_d;
    logic [NUM_EXC-1:0] pending_q, pending_d;

    logic [NUM_EXC-1:0] eligible;
    logic [NUM_EXC-1:0] clr;
    logic [CAUSE_W-1:0] exc_idx;
    logic               take_exc;
    logic [WIDTH-1:0]   src_val;
    logic [WIDTH-1:0]   vec_val;

    // Only the registered pending bits are eligible, so a request arriving
    // on the same edge as load waits for a later load.
    assign eligible = pending_q & ~exc_mask;
    assign take_exc = load & (|eligible);

    // Fixed priority: walk from the top down so the lowest set index wins.
    always_comb begin
        exc_idx = '0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                exc_idx = CAUSE_W'(i);
            end
        end
    end

    // Isolate the lowest set bit of eligible. This is the same cause that
    // exc_idx encodes.
    always_comb begin
        clr = '0;
        if (take_exc) begin
            clr = eligible & (~eligible + NUM_EXC'(1));
        end
    end

    // Out-of-range selects fall back to source 0.
    always_comb begin
        src_val = data_in[0 +: WIDTH];
        for (int k = 0; k < NUM_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                src_val = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    // The vector address wraps modulo 2^WIDTH.
    assign vec_val = WIDTH'(VEC_BASE) + WIDTH'(exc_idx);

    always_comb begin
        data_d    = data_q;
        cause_d   = cause_q;
        taken_d   = 1'b0;
        // A new request wins over the clear for the cause taken on this edge.
        pending_d = (pending_q & ~clr) | exc_req;
        if (load) begin
            if (take_exc) begin
                data_d  = vec_val;
                cause_d = exc_idx;
                taken_d = 1'b1;
            end else begin
                data_d  = src_val;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_q    <= '0;
            cause_q   <= '0;
            taken_q   <= 1'b0;
            pending_q <= '0;
        end else begin
            data_q    <= data_d;
            cause_q   <= cause_d;
            taken_q   <= taken_d;
            pending_q <= pending_d;
        end
    end

    assign data_out  = data_q;
    assign cause     = cause_q;
    assign exc_taken = taken_q;
    assign pending   = pending_q;

endmodule

// File: tb/tb_pc_source_sel.sv
module tb_pc_source_sel;

  localparam int WIDTH   = 32;
  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;
  localparam int NUM_EXC = 3;
  localparam int CAUSE_W = 2;
  localparam int EW      = WIDTH + CAUSE_W + 1;

  logic                     clk;
  logic                     reset;
  logic [SEL_W-1:0]         sel;
  logic [NUM_SRC*WIDTH-1:0] data_in;
  logic [NUM_EXC-1:0]       exc_req;
  logic [NUM_EXC-1:0]       exc_mask;
  logic                     load;
  logic [WIDTH-1:0]         data_out;
  logic [CAUSE_W-1:0]       cause;
  logic                     exc_taken;
  logic [NUM_EXC-1:0]       pending;

  int checks = 0;
  int errors = 0;

  // Each entry is {data_out, cause, exc_taken} expected after one load edge.
  logic [EW-1:0] exp_q[$];

  pc_source_sel #(
    .WIDTH(WIDTH), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
    .NUM_EXC(NUM_EXC), .CAUSE_W(CAUSE_W), .VEC_BASE(253)
  ) dut (
    .clk(clk), .reset(reset), .sel(sel), .data_in(data_in),
    .exc_req(exc_req), .exc_mask(exc_mask), .load(load),
    .data_out(data_out), .cause(cause), .exc_taken(exc_taken),
    .pending(pending)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // checking helpers
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [31:0] d, input logic [31:0] c,
                         input logic [31:0] t, input logic [31:0] p);
    chk({name, ".data_out"}, data_out, d);
    chk({name, ".cause"}, 32'(cause), c);
    chk({name, ".exc_taken"}, 32'(exc_taken), t);
    chk({name, ".pending"}, 32'(pending), p);
  endtask

  task automatic expect_load(input logic [WIDTH-1:0] d, input logic [CAUSE_W-1:0] c, input logic t);
    exp_q.push_back({d, c, t});
  endtask

  // driver: apply inputs at a falling edge, return at the next falling edge
  task automatic cycle(input logic ld, input logic [SEL_W-1:0] s,
                       input logic [NUM_EXC-1:0] req, input logic [NUM_EXC-1:0] msk);
    load     = ld;
    sel      = s;
    exc_req  = req;
    exc_mask = msk;
    @(negedge clk);
  endtask

  // monitor: every load edge outside reset produces one output to check
  initial begin
    logic          ld_seen;
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      ld_seen = load & reset;
      @(negedge clk);
      if (ld_seen) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_empty: load edge with no expected entry, data_out=0x%0h", data_out);
        end else begin
          e = exp_q.pop_front();
          chk("sb.data_out", data_out, e[EW-1 -: WIDTH]);
          chk("sb.cause", 32'(cause), 32'(e[CAUSE_W:1]));
          chk("sb.exc_taken", 32'(exc_taken), 32'(e[0]));
        end
      end
    end
  end

  // stimulus
  initial begin
    reset    = 1'b0;
    load     = 1'b1;
    sel      = 2'd3;
    exc_req  = 3'b111;
    exc_mask = 3'b000;
    data_in  = {32'hdead_beef, 32'h1234_5678, 32'hcafe_f00d, 32'h5555_aaaa};

    // 1. reset and hold
    @(negedge clk);
    chk_all("rst_active", 0, 0, 0, 0);
    @(negedge clk);
    chk_all("rst_active2", 0, 0, 0, 0);
    load    = 1'b0;
    exc_req = 3'b000;
    reset   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'd0, 3'b000, 3'b000);
      chk_all("rst_hold", 0, 0, 0, 0);
    end

    // 2. source select
    data_in = {32'h30, 32'h20, 32'h10, 32'h00};
    expect_load(32'h20, 2'd0, 1'b0);
    cycle(1'b1, 2'd2, 3'b000, 3'b000);
    expect_load(32'h30, 2'd0, 1'b0);
    cycle(1'b1, 2'd3, 3'b000, 3'b000);
    cycle(1'b0, 2'd0, 3'b000, 3'b000);
    chk_all("src_hold", 32'h30, 0, 0, 0);

    // 3. exception vector
    cycle(1'b0, 2'd0, 3'b010, 3'b000);
    chk("exc_pend_set", 32'(pending), 32'b010);
    expect_load(32'd254, 2'd1, 1'b1);
    cycle(1'b1, 2'd1, 3'b000, 3'b000);
    chk("exc_pend_clr", 32'(pending), 32'b000);
    expect_load(32'h10, 2'd1, 1'b0);
    cycle(1'b1, 2'd1, 3'b000, 3'b000);
    cycle(1'b0, 2'd0, 3'b000, 3'b000);
    chk_all("exc_after", 32'h10, 1, 0, 0);

    // 4. priority and queueing
    cycle(1'b0, 2'd0, 3'b110, 3'b000);
    chk("prio_pend", 32'(pending), 32'b110);
    expect_load(32'd254, 2'd1, 1'b1);
    cycle(1'b1, 2'd0, 3'b000, 3'b000);
    chk("prio_pend1", 32'(pending), 32'b100);
    expect_load(32'd255, 2'd2, 1'b1);
    cycle(1'b1, 2'd0, 3'b000, 3'b000);
    chk("prio_pend2", 32'(pending), 32'b000);
    cycle(1'b0, 2'd0, 3'b000, 3'b000);
    chk_all("prio_hold", 32'd255, 2, 0, 0);

    // 5. masking (distinct source values so source 0 is visible)
    data_in = {32'h33, 32'h22, 32'h11, 32'h44};
    cycle(1'b0, 2'd0, 3'b001, 3'b001);
    expect_load(32'h44, 2'd2, 1'b0);
    cycle(1'b1, 2'd0, 3'b000, 3'b001);
    chk("mask_pend_kept", 32'(pending), 32'b001);
    cycle(1'b0, 2'd0, 3'b000, 3'b000);
    chk("mask_drop_pend", 32'(pending), 32'b001);
    expect_load(32'd253, 2'd0, 1'b1);
    cycle(1'b1, 2'd0, 3'b000, 3'b000);
    chk("mask_taken_pend", 32'(pending), 32'b000);

    // 6. simultaneous set and clear
    cycle(1'b0, 2'd0, 3'b001, 3'b000);
    expect_load(32'd253, 2'd0, 1'b1);
    cycle(1'b1, 2'd3, 3'b001, 3'b000);
    chk("setclr_pend", 32'(pending), 32'b001);
    expect_load(32'd253, 2'd0, 1'b1);
    cycle(1'b1, 2'd2, 3'b000, 3'b000);
    // request arriving with load is not eligible on that edge
    expect_load(32'h22, 2'd0, 1'b0);
    cycle(1'b1, 2'd2, 3'b100, 3'b000);
    chk("late_req_pend", 32'(pending), 32'b100);
    expect_load(32'd255, 2'd2, 1'b1);
    cycle(1'b1, 2'd0, 3'b010, 3'b000);
    chk_all("pre_reset", 32'd255, 2, 1, 32'b010);

    // reset between clock edges
    load    = 1'b0;
    exc_req = 3'b000;
    #2;
    reset = 1'b0;
    #1;
    chk_all("async_reset", 0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    expect_load(32'h11, 2'd0, 1'b0);
    cycle(1'b1, 2'd1, 3'b000, 3'b000);
    cycle(1'b0, 2'd0, 3'b000, 3'b000);
    chk_all("post_reset", 32'h11, 0, 0, 0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
